// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg: shared types and constants for the 4-digit 7-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}; table entries are active-high.
package seg_pkg;

  localparam int SEG_W = 7;
  localparam int NDIG  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // hex digit -> segment pattern, gfedcba, active-high
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_if: digit inputs, scan enable and display pin outputs of the scanner.
// master = display-select mux side, slave = scanner.
interface seg_scan_if;
  import seg_pkg::*;

  logic             en;
  logic [3:0]       dig0;
  logic [3:0]       dig1;
  logic [3:0]       dig2;
  logic [3:0]       dig3;
  logic [SEG_W-1:0] seg;
  logic [NDIG-1:0]  an;
  logic             frame_tick;

  modport master (
    output en, dig0, dig1, dig2, dig3,
    input  seg, an, frame_tick
  );

  modport slave (
    input  en, dig0, dig1, dig2, dig3,
    output seg, an, frame_tick
  );

endinterface

// File: rtl/seg_scan_driver_decode.sv
// hex7seg_decode: combinational 4-bit hex to 7-segment (gfedcba) decoder, active-high.
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit 7-segment scanner.
// Each slot is DIV_MAX+1 clocks: DEAD blank clocks, then the decoded digit.
// Digits are snapshotted at every frame start so a frame never tears.
// Optional build macro SEG_LZ_BLANK_EN: leading-zero blanking on the snapshot.
//
//   state | meaning
//   IDLE  | scan disabled, all pins OFF
//   BLANK | dead-time at the start of a slot, all pins OFF
//   SHOW  | an[idx] lit with decode(snapshot[idx])
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int DIV_MAX    = 49999,
  parameter int DEAD       = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_MAX_C = DIV_W'(DIV_MAX);
  localparam logic [DIV_W:0]   DEAD_C    = (DIV_W+1)'(DEAD);
  localparam state_t           SLOT_ST   = (DEAD == 0) ? ST_SHOW : ST_BLANK;
  localparam logic [SEG_W-1:0] SEG_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NDIG-1:0]  AN_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

  state_t           state_q;
  logic [DIV_W-1:0] presc_q;
  logic [1:0]       idx_q;
  logic [3:0]       snap_q [NDIG];
  logic [SEG_W-1:0] seg_q;
  logic [NDIG-1:0]  an_q;
  logic             tick_q;

  state_t           nxt_state;
  logic [DIV_W-1:0] nxt_presc;
  logic [1:0]       nxt_idx;
  logic             frame_start;
  logic [3:0]       dig_in   [NDIG];
  logic [3:0]       nxt_snap [NDIG];
  logic [3:0]       sel_dig;
  logic [SEG_W-1:0] dec_seg;
  logic             dark;
  logic             lit;
  logic [SEG_W-1:0] nxt_seg;
  logic [NDIG-1:0]  nxt_an;

  assign dig_in[0] = bus.dig0;
  assign dig_in[1] = bus.dig1;
  assign dig_in[2] = bus.dig2;
  assign dig_in[3] = bus.dig3;

  // next state, prescaler and digit index; en=0 overrides everything, including slot end
  always_comb begin
    nxt_state   = state_q;
    nxt_presc   = presc_q;
    nxt_idx     = idx_q;
    frame_start = 1'b0;
    if (!bus.en) begin
      nxt_state = ST_IDLE;
      nxt_presc = '0;
      nxt_idx   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          frame_start = 1'b1;
          nxt_presc   = '0;
          nxt_idx     = '0;
          nxt_state   = SLOT_ST;
        end
        default: begin
          if (presc_q == DIV_MAX_C) begin
            nxt_presc   = '0;
            nxt_idx     = idx_q + 2'd1;
            frame_start = (idx_q == 2'd3);
            nxt_state   = SLOT_ST;
          end else begin
            nxt_presc = presc_q + 1'b1;
            if (state_q == ST_BLANK && ({1'b0, presc_q} + 1'b1) < DEAD_C)
              nxt_state = ST_BLANK;
            else
              nxt_state = ST_SHOW;
          end
        end
      endcase
    end
  end

  // snapshot view for the coming cycle: fresh inputs on a frame start, held copy otherwise
  always_comb begin
    for (int i = 0; i < NDIG; i++)
      nxt_snap[i] = frame_start ? dig_in[i] : snap_q[i];
    sel_dig = nxt_snap[nxt_idx];
  end

`ifdef SEG_LZ_BLANK_EN
  // leading-zero suppression; the rightmost digit always shows
  always_comb begin
    dark = 1'b0;
    case (nxt_idx)
      2'd3: dark = (nxt_snap[3] == 4'd0);
      2'd2: dark = (nxt_snap[3] == 4'd0) && (nxt_snap[2] == 4'd0);
      2'd1: dark = (nxt_snap[3] == 4'd0) && (nxt_snap[2] == 4'd0) && (nxt_snap[1] == 4'd0);
      default: dark = 1'b0;
    endcase
  end
`else
  assign dark = 1'b0;
`endif

  hex7seg_decode u_dec (
    .hex (sel_dig),
    .seg (dec_seg)
  );

  assign lit     = (nxt_state == ST_SHOW) && !dark;
  assign nxt_seg = lit ? (dec_seg ^ SEG_OFF) : SEG_OFF;
  assign nxt_an  = lit ? ((NDIG'(1) << nxt_idx) ^ AN_OFF) : AN_OFF;

  // scan FSM with registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      idx_q   <= '0;
      for (int i = 0; i < NDIG; i++) snap_q[i] <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= nxt_state;
      presc_q <= nxt_presc;
      idx_q   <= nxt_idx;
      if (frame_start)
        for (int i = 0; i < NDIG; i++) snap_q[i] <= dig_in[i];
      seg_q   <= nxt_seg;
      an_q    <= nxt_an;
      tick_q  <= frame_start;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule
